// File: rtl/carrier_loop_filter_pkg.sv
// Shared widths, loop-gain defaults and saturating add for the MSK carrier loop.
// Optional lock detector in carrier_loop_filter is enabled by CARRIER_LOCK_DET_EN.
package carrier_loop_pkg;

    localparam int EW_DEF       = 24;
    localparam int FW_DEF       = 32;
    localparam int KP_SHIFT_DEF = 4;
    localparam int KI_SHIFT_DEF = 10;
    localparam int SAT_W        = 64;

    // a + b evaluated one bit wider, then clamped to the signed w-bit range (w <= SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = (SAT_W+1)'(a) + (SAT_W+1)'(b);
        hi  = (signed'((SAT_W+1)'(1)) <<< (w - 1)) - signed'((SAT_W+1)'(1));
        lo  = -hi - signed'((SAT_W+1)'(1));
        if (sum > hi) begin
            return SAT_W'(hi);
        end
        if (sum < lo) begin
            return SAT_W'(lo);
        end
        return SAT_W'(sum);
    endfunction

endpackage

// File: rtl/carrier_loop_filter_if.sv
// Symbol-rate phase-error input and frequency-word output of the carrier loop filter.
// Shared by the loop filter whether or not CARRIER_LOCK_DET_EN is defined.
interface carrier_loop_filter_if
    import carrier_loop_pkg::*;
#(
    parameter int EW = EW_DEF,
    parameter int FW = FW_DEF
);
    logic                 err_valid;
    logic signed [EW-1:0] phase_err;
    logic                 freq_valid;
    logic signed [FW-1:0] freq_word;

    modport master (
        output err_valid,
        output phase_err,
        input  freq_valid,
        input  freq_word
    );

    modport slave (
        input  err_valid,
        input  phase_err,
        output freq_valid,
        output freq_word
    );
endinterface

// File: rtl/carrier_loop_filter_lock_det.sv
// Carrier lock detector: counts consecutive small phase errors, saturating at LOCK_CNT.
// Instantiated by carrier_loop_filter only when CARRIER_LOCK_DET_EN is defined.
module carrier_lock_det #(
    parameter int EW       = 24,
    parameter int LOCK_THR = 262144,
    parameter int LOCK_CNT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 err_valid,
    input  logic signed [EW-1:0] phase_err,
    output logic                 locked
);
    localparam int                   CW      = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0]        CNT_MAX = CW'(LOCK_CNT);
    localparam logic signed [EW-1:0] ERR_MIN = {1'b1, {(EW-1){1'b0}}};

    logic [CW-1:0]     cnt;
    logic signed [EW:0] mag;
    logic              in_thr;

    // One extra bit keeps |most-negative| representable; it is still rejected explicitly.
    always_comb begin
        mag = (EW+1)'(phase_err);
        if (phase_err[EW-1]) begin
            mag = -mag;
        end
        in_thr = (phase_err != ERR_MIN) && (64'(mag) < 64'(LOCK_THR));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (err_valid) begin
            if (!in_thr) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign locked = (cnt == CNT_MAX);

endmodule

// File: rtl/carrier_loop_filter.sv
// PI loop filter turning per-symbol phase error into a saturated NCO frequency word.
// Define CARRIER_LOCK_DET_EN to build the lock detector; otherwise locked is tied low.
module carrier_loop_filter
    import carrier_loop_pkg::*;
#(
    parameter int EW       = EW_DEF,
    parameter int FW       = FW_DEF,
    parameter int KP_SHIFT = KP_SHIFT_DEF,
    parameter int KI_SHIFT = KI_SHIFT_DEF,
    parameter int LOCK_THR = 262144,
    parameter int LOCK_CNT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    carrier_loop_filter_if.slave lf,
    input  logic                 hold,
    input  logic                 clr,
    output logic signed [FW-1:0] integ_out,
    output logic                 locked
);
    if (FW < EW || KI_SHIFT < KP_SHIFT || LOCK_CNT < 1 || LOCK_THR < 1) begin : g_bad_params
        $error("carrier_loop_filter: illegal parameter combination");
    end

    logic signed [FW-1:0] e_ext;
    logic signed [FW-1:0] p_q;
    logic signed [FW-1:0] inc_q;
    logic                 v1;
    logic signed [FW-1:0] integ;
    logic signed [FW-1:0] integ_next;
    logic signed [FW-1:0] freq_next;

    // Left-justify the error so full-scale input lands on full-scale FW.
    assign e_ext = FW'(lf.phase_err) <<< (FW - EW);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            p_q   <= '0;
            inc_q <= '0;
        end else if (clr) begin
            v1 <= 1'b0;
        end else begin
            v1 <= lf.err_valid;
            if (lf.err_valid) begin
                p_q   <= e_ext >>> KP_SHIFT;
                inc_q <= e_ext >>> KI_SHIFT;
            end
        end
    end

    always_comb begin
        integ_next = integ;
        if (!hold) begin
            integ_next = FW'(sat_add(SAT_W'(integ), SAT_W'(inc_q), FW));
        end
        freq_next = FW'(sat_add(SAT_W'(integ_next), SAT_W'(p_q), FW));
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            integ         <= '0;
            lf.freq_word  <= '0;
            lf.freq_valid <= 1'b0;
        end else begin
            lf.freq_valid <= v1;
            if (v1) begin
                integ        <= integ_next;
                lf.freq_word <= freq_next;
            end
        end
    end

    assign integ_out = integ;

`ifdef CARRIER_LOCK_DET_EN
    carrier_lock_det #(
        .EW       (EW),
        .LOCK_THR (LOCK_THR),
        .LOCK_CNT (LOCK_CNT)
    ) u_lock_det (
        .clk       (clk),
        .rst       (rst),
        .err_valid (lf.err_valid),
        .phase_err (lf.phase_err),
        .locked    (locked)
    );
`else
    assign locked = 1'b0;
`endif

endmodule
